// File: rtl/rv32i_pkg.sv
// Shared definitions for the memory responder: control FSM encoding, bus widths and a
// byte-lane mask helper.
package rv32i_pkg;

  localparam int unsigned MASK_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 7;
  // Wide enough for a latency counter holding up to 14 (LATENCY max 15, loaded with LATENCY-1).
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Expand one enable bit per byte lane into a full-width bit mask.
  function automatic logic [DATA_W-1:0] lane_expand(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < MASK_W; i++) begin
      res[8*i +: 8] = {8{m[i]}};
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_mask_ram.sv
// Word-addressed storage with per-byte-lane write enables and a lane-masked
// asynchronous read port. Contents are never reset.
module byte_mask_ram
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 128
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [MASK_W-1:0] i_wmask,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [MASK_W-1:0] i_rmask,
  output logic [DATA_W-1:0] o_rdata
);

  // Index width rounded up to a power of two; callers only present in-range addresses.
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Words = 1 << IdxW;

  logic [DATA_W-1:0] r_mem [Words];
  logic [IdxW-1:0]   w_widx;
  logic [IdxW-1:0]   w_ridx;

  assign w_widx = IdxW'(i_waddr);
  assign w_ridx = IdxW'(i_raddr);

  // Byte-lane write: only lanes with their mask bit set are updated.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (i_wmask[i]) begin
          r_mem[w_widx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Masked read: disabled lanes read back as zero.
  always_comb begin
    o_rdata = r_mem[w_ridx] & lane_expand(i_rmask);
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request while idle, waits a fixed
// latency, then presents a one-cycle response strobe with read data or the written word.
module mem_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr_en,
  input  logic [MASK_W-1:0] mask,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] r_data,
  output logic              err
);

  localparam logic [CNT_W-1:0]  LatInit = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  state_e            w_state_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_d;
  logic              w_accept;
  logic              w_enter_resp;

  logic              r_wr;
  logic [MASK_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_from_idle;
  logic              w_wr_en;
  logic [MASK_W-1:0] w_wr_mask;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_in_range;
  logic              w_we;
  logic              w_rd_in_range;
  logic [MASK_W-1:0] w_rd_mask;
  logic [DATA_W-1:0] w_ram_rdata;

  // State and latency counter register; reset aborts any in-flight transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state logic: IDLE -> WAIT (or straight to RESP when LATENCY is 1) -> RESP -> IDLE.
  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_d    = StResp;
            w_enter_resp = 1'b1;
            w_cnt_d      = '0;
          end else begin
            w_state_d = StWait;
            w_cnt_d   = LatInit;
          end
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - CntOne;
        if (r_cnt == CntOne) begin
          w_state_d    = StResp;
          w_enter_resp = 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Capture the request fields on acceptance; they stay stable until the next acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_mask  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= wr_en;
      r_mask  <= mask;
      r_addr  <= mem_addr;
      r_wdata <= w_data;
    end
  end

  // Write-port source: live inputs when jumping IDLE->RESP, captured fields otherwise.
  always_comb begin
    w_from_idle   = (r_state == StIdle);
    w_wr_en       = w_from_idle ? wr_en    : r_wr;
    w_wr_mask     = w_from_idle ? mask     : r_mask;
    w_wr_addr     = w_from_idle ? mem_addr : r_addr;
    w_wr_data     = w_from_idle ? w_data   : r_wdata;
    w_wr_in_range = ({1'b0, w_wr_addr} < DepthL);
    // Gating with rst keeps a request presented during reset from touching memory.
    w_we          = w_enter_resp & w_wr_en & w_wr_in_range & rst;
  end

  // Read side always follows the captured request; writes read back the full word.
  always_comb begin
    w_rd_in_range = ({1'b0, r_addr} < DepthL);
    w_rd_mask     = r_wr ? {MASK_W{1'b1}} : r_mask;
  end

  byte_mask_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wmask (w_wr_mask),
    .i_wdata (w_wr_data),
    .i_raddr (r_addr),
    .i_rmask (w_rd_mask),
    .o_rdata (w_ram_rdata)
  );

  // Response outputs decoded from state; data and error are zero outside the strobe.
  always_comb begin
    ready  = (r_state == StIdle);
    valid  = (r_state == StResp);
    err    = 1'b0;
    r_data = '0;
    if (valid) begin
      if (w_rd_in_range) begin
        r_data = w_ram_rdata;
      end else begin
        err = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a word-array reference model predicts
// every response and the cycle it must appear in; a separate monitor checks the outputs.
module tb_mem_responder;

  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 64;
  localparam int unsigned PER = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [6:0]  mem_addr = 7'h0;
  logic [31:0] w_data = 32'h0;
  logic        ready;
  logic        valid;
  logic [31:0] r_data;
  logic        err;

  mem_responder #(
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr_en    (wr_en),
    .mask     (mask),
    .mem_addr (mem_addr),
    .w_data   (w_data),
    .ready    (ready),
    .valid    (valid),
    .r_data   (r_data),
    .err      (err)
  );

  always #(PER / 2) clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_model [DEP];
  int          cyc = 0;
  int          next_free = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  bit          model_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Posedge counter; everything else samples on the falling edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: a request accepted on edge a answers in the cycle after edge
  // a+LAT-1 and the next request can be taken on edge a+LAT+1.
  task automatic accept(input bit we, input logic [3:0] m, input logic [6:0] ad,
                        input logic [31:0] d);
    exp_t        e;
    logic [31:0] word;
    int          a;
    a         = cyc + 1;
    e.due     = a + int'(LAT) - 1;
    next_free = a + int'(LAT) + 1;
    e.err     = 1'b0;
    e.data    = 32'h0;
    if (int'(ad) >= int'(DEP)) begin
      e.err = 1'b1;
    end else begin
      word = mem_model[ad];
      for (int i = 0; i < 4; i++) begin
        if (we) begin
          if (m[i]) word[8*i +: 8] = d[8*i +: 8];
          e.data[8*i +: 8] = word[8*i +: 8];
        end else begin
          e.data[8*i +: 8] = m[i] ? word[8*i +: 8] : 8'h00;
        end
      end
      if (we) mem_model[ad] = word;
    end
    q.push_back(e);
  endtask

  // One clock of stimulus, driven on the falling edge.
  task automatic step(input bit rq, input bit we, input logic [3:0] m, input logic [6:0] ad,
                      input logic [31:0] d);
    bit fr;
    @(negedge clk);
    fr = (cyc + 1 >= next_free);
    if (rst) chk("ready", ready, fr);
    req      = rq;
    wr_en    = we;
    mask     = m;
    mem_addr = ad;
    w_data   = d;
    if (rq && fr && rst && !model_off) accept(we, m, ad, d);
  endtask

  task automatic issue(input bit we, input logic [3:0] m, input logic [6:0] ad,
                       input logic [31:0] d);
    int guard;
    guard = 0;
    while (cyc + 1 < next_free && guard < 64) begin
      step(1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
      guard++;
    end
    chk("issue_slot_bound", guard < 64, 1'b1);
    step(1'b1, we, m, ad, d);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    q.delete();
    next_free = 0;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_err", err, 1'b0);
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares every cycle against the head of the expectation queue.
  initial begin
    exp_t e;
    bit   exp_v;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_v = (q.size() > 0 && q[0].due == cyc);
        chk("valid", valid, exp_v);
        if (exp_v) begin
          e = q.pop_front();
          chk("r_data", r_data, e.data);
          chk("err", err, e.err);
        end else begin
          chk("idle_r_data", r_data, 32'h0);
          chk("idle_err", err, 1'b0);
        end
        if (prev_valid) chk("ready_after_valid", ready, 1'b1);
        prev_valid = valid;
      end
    end
  end

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ad;
    // Power-on reset: outputs must settle without a clock edge.
    rst = 1'b0;
    #1;
    chk("por_ready", ready, 1'b1);
    chk("por_valid", valid, 1'b0);
    chk("por_r_data", r_data, 32'h0);
    chk("por_err", err, 1'b0);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Preload every word so later reads have defined contents.
    for (int a = 0; a < int'(DEP); a++) issue(1'b1, 4'hF, 7'(a), $urandom);

    // Full write/read, then partial write and masked read at address 5.
    issue(1'b1, 4'hF, 7'd5, 32'hDEADBEEF);
    issue(1'b0, 4'hF, 7'd5, 32'h0);
    issue(1'b1, 4'b0101, 7'd5, 32'h11223344);
    issue(1'b0, 4'b0011, 7'd5, 32'h0);
    issue(1'b0, 4'hF, 7'd5, 32'h0);

    // Empty mask: write changes nothing, read returns zero.
    issue(1'b1, 4'h0, 7'd7, 32'hFFFFFFFF);
    issue(1'b0, 4'h0, 7'd7, 32'h0);
    issue(1'b0, 4'hF, 7'd7, 32'h0);

    // Out-of-range write must not alias onto address 70 mod 64.
    issue(1'b1, 4'hF, 7'd70, 32'h5A5A5A5A);
    issue(1'b0, 4'hF, 7'd6, 32'h0);
    issue(1'b0, 4'hF, 7'd127, 32'h0);

    // Request held high with changing data: only spaced acceptances take effect.
    repeat (3 * (LAT + 1) + 1) step(1'b1, 1'b1, 4'hF, 7'd3, $urandom);
    issue(1'b0, 4'hF, 7'd3, 32'h0);

    // Reset during WAIT: the pending write to 9 must be dropped.
    issue(1'b0, 4'hF, 7'd9, 32'h0);
    while (cyc + 1 < next_free) step(1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    model_off = 1'b1;
    step(1'b1, 1'b1, 4'hF, 7'd9, 32'hCAFEF00D);
    model_off = 1'b0;
    do_reset(2);
    issue(1'b0, 4'hF, 7'd9, 32'h0);

    // Randomized traffic, biased toward in-range addresses.
    repeat (700) begin
      ad = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(64, 127))
                                       : 7'($urandom_range(0, 63));
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ad,
           $urandom);
    end

    repeat (LAT + 3) step(1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
